lb2apb_bridge: RTL and testbench
================================

LB2APB_BRIDGE -- requirements
Module: lb2apb_bridge

Interface
REQ-001 Parameter ADDR_W, default 8, local bus and APB address width.
REQ-002 Parameter DATA_W, default 16, data width; SHALL be a multiple of 8.
REQ-003 Parameter STRB_W, default DATA_W/8, byte strobe width.
REQ-004 Parameter TIMEOUT, default 255, maximum ACCESS cycles without pready; range 1..65535.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 lb_waddr, lb_wdata, lb_wstrb  in  ADDR_W/DATA_W/STRB_W  write request fields, valid while lb_wen=1.
REQ-008 lb_wen  in  1  write request; held high until lb_wready is seen.
REQ-009 lb_wready  out  1  one-cycle write completion pulse.
REQ-010 lb_raddr  in  ADDR_W  read address, valid while lb_ren=1.
REQ-011 lb_ren  in  1  read request; held high until lb_rvalid is seen.
REQ-012 lb_rdata  out  DATA_W  read data, valid when lb_rvalid=1.
REQ-013 lb_rvalid  out  1  one-cycle read completion pulse.
REQ-014 psel, penable, pwrite  out  1 each  APB control.
REQ-015 paddr, pwdata, pstrb  out  ADDR_W/DATA_W/STRB_W  APB request fields.
REQ-016 prdata, pready, pslverr  in  DATA_W/1/1  APB completer response.
REQ-017 err_slv, err_tmo  out  1 each  sticky flags: pslverr seen; TIMEOUT expired.
REQ-018 err_clr  in  1  synchronous clear of both sticky flags.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, SETUP, ACCESS, RESP.
REQ-020 IDLE: on lb_wen=1, latch waddr/wdata/wstrb, set pwrite=1, go to SETUP; else on lb_ren=1, latch raddr, pstrb=0, pwrite=0, go to SETUP.
REQ-021 Simultaneous lb_wen and lb_ren in IDLE: the write SHALL be served first; the read SHALL be served on the next IDLE visit.
REQ-022 SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-023 ACCESS: psel=1, penable=1; hold paddr/pwdata/pstrb/pwrite stable; go to RESP on pready=1 or on timeout.
REQ-024 The timeout counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready=0.
REQ-025 Timeout SHALL fire when the count reaches TIMEOUT: set err_tmo, abort the APB transfer (psel=0), go to RESP.
REQ-026 On pready=1 with pslverr=1, set err_slv; the local bus completion SHALL still occur.
REQ-027 RESP: psel=penable=0; pulse lb_wready (write) or lb_rvalid (read) for exactly one cycle, then go to IDLE.
REQ-028 Read data: lb_rdata SHALL be prdata registered at pready; it SHALL be 0 on timeout or pslverr, and hold its value outside lb_rvalid.
REQ-029 Latency: request sampled in IDLE at cycle 0 with zero-wait completer -> SETUP cycle 1, ACCESS cycle 2, completion pulse cycle 3.
REQ-030 No new request SHALL be accepted in the cycle the completion pulse is high; the earliest next SETUP is 2 cycles after the pulse.
REQ-031 err_clr coinciding with a new error event: set SHALL win.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 On rst_n=0, regardless of clk: state=IDLE; psel, penable, pwrite, lb_wready, lb_rvalid, err_slv, err_tmo, counter = 0; paddr, pwdata, pstrb, lb_rdata = 0.
REQ-034 Reset asserted mid-transfer SHALL drop psel immediately; no completion pulse SHALL be issued for the aborted request.

Structure
REQ-035 Package lb2apb_pkg SHALL hold the state encodings and the default TIMEOUT constant.
REQ-036 One sub-module, lb2apb_wdt (clearable up-counter with terminal-count flag), SHALL implement the timeout counter.

Verification
REQ-037 Write addr 0x12, data 0xA5C3, strb 2'b11, pready tied 1 -> one APB write with pwrite=1; lb_wready pulse at cycle 3; err flags stay 0.
REQ-038 Read addr 0x34, prdata 0xBEEF, pready after 4 wait cycles -> lb_rvalid pulse with lb_rdata=0xBEEF at cycle 7.
REQ-039 Read with pready held 0, TIMEOUT=255 -> psel drops after 255 ACCESS cycles; lb_rvalid pulse with lb_rdata=0; err_tmo=1 until err_clr.
REQ-040 lb_wen and lb_ren asserted in the same cycle -> write APB transfer completes first, then read; exactly one wready and one rvalid pulse.
REQ-041 Write with pslverr=1 -> err_slv=1 and lb_wready pulse; err_clr together with a second pslverr -> err_slv stays 1.
REQ-042 rst_n pulsed low during ACCESS -> psel=0 asynchronously; no wready/rvalid pulse; next request after reset completes normally.

Source files
------------

// File: rtl/lb2apb_pkg.sv
// Shared definitions for the local-bus to APB bridge: FSM encoding and
// watchdog defaults.
package lb2apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int unsigned TIMEOUT_DEF = 255;
    // Wide enough for the largest allowed TIMEOUT (65535).
    localparam int unsigned TMO_CNT_W   = 16;

endpackage

// File: rtl/lb2apb_wdt.sv
// Clearable up-counter for APB wait states; tc_o flags the increment that
// makes the count reach LIMIT.
module lb2apb_wdt
    import lb2apb_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);

    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/lb2apb_bridge.sv
// Local-bus (separate write/read request ports) to APB requester bridge with
// wait-state watchdog and sticky error flags. All outputs are registered.
module lb2apb_bridge
    import lb2apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned STRB_W  = DATA_W / 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lb_waddr,
    input  logic [DATA_W-1:0] lb_wdata,
    input  logic [STRB_W-1:0] lb_wstrb,
    input  logic              lb_wen,
    output logic              lb_wready,
    input  logic [ADDR_W-1:0] lb_raddr,
    input  logic              lb_ren,
    output logic [DATA_W-1:0] lb_rdata,
    output logic              lb_rvalid,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              err_slv,
    output logic              err_tmo,
    input  logic              err_clr
);

    state_e state_q, state_d;

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wready_q, wready_d;
    logic              rvalid_q, rvalid_d;
    logic              err_slv_q, err_slv_d;
    logic              err_tmo_q, err_tmo_d;

    logic accept;
    logic tmo_fire;

    assign accept = (state_q == ST_IDLE) && (lb_wen || lb_ren);

    lb2apb_wdt #(
        .LIMIT (TIMEOUT)
    ) u_wdt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .inc_i ((state_q == ST_ACCESS) && !pready),
        .tc_o  (tmo_fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (lb_wen || lb_ren) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (pready || tmo_fire) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output values are computed from the next state so every port can be
    // driven straight from a flop without adding latency.
    always_comb begin
        psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d = (state_d == ST_ACCESS);
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        rdata_d   = rdata_q;
        err_slv_d = err_slv_q && !err_clr;
        err_tmo_d = err_tmo_q && !err_clr;

        case (state_q)
            ST_IDLE: begin
                if (lb_wen) begin
                    pwrite_d = 1'b1;
                    paddr_d  = lb_waddr;
                    pwdata_d = lb_wdata;
                    pstrb_d  = lb_wstrb;
                end else if (lb_ren) begin
                    pwrite_d = 1'b0;
                    paddr_d  = lb_raddr;
                    pstrb_d  = '0;
                end
            end
            ST_ACCESS: begin
                if (pready) begin
                    if (pslverr) err_slv_d = 1'b1;
                    if (!pwrite_q) rdata_d = pslverr ? '0 : prdata;
                end else if (tmo_fire) begin
                    err_tmo_d = 1'b1;
                    if (!pwrite_q) rdata_d = '0;
                end
            end
            default: ;
        endcase

        wready_d = (state_d == ST_RESP) && pwrite_q;
        rvalid_d = (state_d == ST_RESP) && !pwrite_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rdata_q   <= '0;
            wready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            err_slv_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            rdata_q   <= rdata_d;
            wready_q  <= wready_d;
            rvalid_q  <= rvalid_d;
            err_slv_q <= err_slv_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign lb_rdata  = rdata_q;
    assign lb_wready = wready_q;
    assign lb_rvalid = rvalid_q;
    assign err_slv   = err_slv_q;
    assign err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_lb2apb_bridge.sv
// Directed bench for lb2apb_bridge: a table of single transfers against a
// scripted APB completer, plus hand-written timeout/priority/reset sequences.
module tb_lb2apb_bridge;

    logic        clk;
    logic        rst_n;
    logic [7:0]  lb_waddr;
    logic [15:0] lb_wdata;
    logic [1:0]  lb_wstrb;
    logic        lb_wen;
    logic        lb_wready;
    logic [7:0]  lb_raddr;
    logic        lb_ren;
    logic [15:0] lb_rdata;
    logic        lb_rvalid;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [15:0] pwdata;
    logic [1:0]  pstrb;
    logic [15:0] prdata;
    logic        pready, pslverr;
    logic        err_slv, err_tmo, err_clr;

    int checks = 0;
    int errors = 0;

    lb2apb_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lb_waddr  (lb_waddr),
        .lb_wdata  (lb_wdata),
        .lb_wstrb  (lb_wstrb),
        .lb_wen    (lb_wen),
        .lb_wready (lb_wready),
        .lb_raddr  (lb_raddr),
        .lb_ren    (lb_ren),
        .lb_rdata  (lb_rdata),
        .lb_rvalid (lb_rvalid),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .err_slv   (err_slv),
        .err_tmo   (err_tmo),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog got no_finish want finish");
        $fatal(1, "simulation time limit");
    end

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  strb;
        int          waits;
        logic        slverr;
        logic        clr_with_ready;
        logic [15:0] prd;
        int          exp_k;
        logic [15:0] exp_rdata;
        logic        exp_slv;
        logic        clr_after;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Cycle 0 is the cycle in which the request is first presented; k is the
    // cycle index at which the completion pulse is seen.
    task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [15:0] wdata,
                           input logic [1:0] strb, input int waits, input logic slverr,
                           input logic clr_with_ready, input logic [15:0] prd,
                           output int pulse_k, output int acc, output logic [15:0] got_rdata,
                           output logic bad_fields, output logic post_pulse,
                           output logic [15:0] post_rdata);
        pulse_k = -1; acc = 0; got_rdata = '0; bad_fields = 1'b0;
        @(posedge clk); #1;
        lb_wen = wr; lb_ren = !wr;
        lb_waddr = wr ? addr : 8'h00; lb_raddr = wr ? 8'h00 : addr;
        lb_wdata = wdata; lb_wstrb = strb;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            err_clr = 1'b0;
            if (lb_wready || lb_rvalid) begin
                pulse_k = k;
                got_rdata = lb_rdata;
                if (lb_wready !== wr || lb_rvalid !== !wr) bad_fields = 1'b1;
                break;
            end
            if (psel && penable) begin
                if (paddr !== addr || pwrite !== wr) bad_fields = 1'b1;
                if (wr && (pwdata !== wdata || pstrb !== strb)) bad_fields = 1'b1;
                if (!wr && pstrb !== 2'b00) bad_fields = 1'b1;
                if (acc >= waits) begin
                    pready = 1'b1; pslverr = slverr; prdata = prd; err_clr = clr_with_ready;
                end else begin
                    pready = 1'b0; pslverr = 1'b0;
                end
                acc++;
            end else begin
                pready = 1'b0; pslverr = 1'b0;
            end
        end
        @(posedge clk); #1;
        lb_wen = 1'b0; lb_ren = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = 16'hDEAD;
        @(negedge clk);
        post_pulse = lb_wready | lb_rvalid;
        post_rdata = lb_rdata;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
    endtask

    int          pk, acc;
    logic [15:0] rd, prd_after;
    logic        bad, postp;

    initial begin
        vecs[0] = '{1'b1, 8'h12, 16'hA5C3, 2'b11, 0, 1'b0, 1'b0, 16'h0000, 3, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h34, 16'h0000, 2'b00, 4, 1'b0, 1'b0, 16'hBEEF, 7, 16'hBEEF, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h55, 16'h1234, 2'b01, 2, 1'b0, 1'b0, 16'h0000, 5, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'hFF, 16'h0000, 2'b00, 0, 1'b0, 1'b0, 16'h0001, 3, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 16'h0000, 2'b00, 1, 1'b1, 1'b0, 16'h7777, 4, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 8'h21, 16'h0F0F, 2'b10, 0, 1'b1, 1'b0, 16'h0000, 3, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 8'h22, 16'hF00F, 2'b11, 3, 1'b1, 1'b1, 16'h0000, 6, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 8'h7E, 16'h0000, 2'b00, 0, 1'b0, 1'b0, 16'hCAFE, 3, 16'hCAFE, 1'b0, 1'b0};

        rst_n = 1'b0; lb_wen = 1'b0; lb_ren = 1'b0; lb_waddr = '0; lb_raddr = '0;
        lb_wdata = '0; lb_wstrb = '0; prdata = 16'hDEAD; pready = 1'b0; pslverr = 1'b0;
        err_clr = 1'b0;
        #2;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_wready", lb_wready, 0);
        check("rst_rvalid", lb_rvalid, 0);
        check("rst_err_slv", err_slv, 0);
        check("rst_err_tmo", err_tmo, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pstrb", pstrb, 0);
        check("rst_rdata", lb_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].waits,
                    vecs[i].slverr, vecs[i].clr_with_ready, vecs[i].prd,
                    pk, acc, rd, bad, postp, prd_after);
            check($sformatf("v%0d_pulse_cycle", i), pk, vecs[i].exp_k);
            check($sformatf("v%0d_apb_fields", i), bad, 0);
            check($sformatf("v%0d_single_pulse", i), postp, 0);
            check($sformatf("v%0d_err_slv", i), err_slv, vecs[i].exp_slv);
            check($sformatf("v%0d_err_tmo", i), err_tmo, 0);
            check($sformatf("v%0d_rdata_hold", i), prd_after, rd);
            if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            if (vecs[i].clr_after) begin
                pulse_clear();
                check($sformatf("v%0d_err_slv_cleared", i), err_slv, 0);
            end
        end

        // Completer never ready: watchdog aborts after 255 ACCESS cycles.
        prdata = 16'h5A5A;
        run_txn(1'b0, 8'h40, 16'h0000, 2'b00, 100000, 1'b0, 1'b0, 16'h5A5A,
                pk, acc, rd, bad, postp, prd_after);
        check("tmo_access_cycles", acc, 255);
        check("tmo_pulse_cycle", pk, 257);
        check("tmo_rdata", rd, 16'h0000);
        check("tmo_err_tmo", err_tmo, 1);
        check("tmo_err_slv", err_slv, 0);
        check("tmo_single_pulse", postp, 0);
        repeat (3) @(negedge clk);
        check("tmo_sticky", err_tmo, 1);
        pulse_clear();
        check("tmo_cleared", err_tmo, 0);

        // Write and read requested together: write is served first.
        begin
            int wk, rk, wcnt, rcnt, nacc;
            logic [1:0] order;
            logic [15:0] rsaw;
            wk = -1; rk = -1; wcnt = 0; rcnt = 0; nacc = 0; order = 2'b00; rsaw = '0;
            @(posedge clk); #1;
            lb_wen = 1'b1; lb_waddr = 8'h0A; lb_wdata = 16'h4321; lb_wstrb = 2'b11;
            lb_ren = 1'b1; lb_raddr = 8'h0B;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (lb_wready) begin wcnt++; wk = k; lb_wen = 1'b0; end
                if (lb_rvalid) begin rcnt++; rk = k; rsaw = lb_rdata; lb_ren = 1'b0; end
                if (psel && penable) begin
                    if (nacc < 2) order[nacc] = pwrite;
                    nacc++;
                    pready = 1'b1; prdata = 16'h1357;
                end else begin
                    pready = 1'b0;
                end
            end
            check("dual_wready_cycle", wk, 3);
            check("dual_rvalid_cycle", rk, 7);
            check("dual_wready_count", wcnt, 1);
            check("dual_rvalid_count", rcnt, 1);
            check("dual_order", order, 2'b01);
            check("dual_rdata", rsaw, 16'h1357);
        end

        // Reset in the middle of ACCESS.
        begin
            int npulse;
            logic reached;
            npulse = 0; reached = 1'b0;
            @(posedge clk); #1;
            lb_wen = 1'b1; lb_waddr = 8'h66; lb_wdata = 16'h9999; lb_wstrb = 2'b11;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (psel && penable) begin reached = 1'b1; break; end
            end
            check("rstmid_reached_access", reached, 1);
            #2; rst_n = 1'b0;
            #1;
            check("rstmid_psel_async", psel, 0);
            check("rstmid_penable_async", penable, 0);
            lb_wen = 1'b0;
            @(negedge clk); rst_n = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (lb_wready || lb_rvalid || psel) npulse++;
            end
            check("rstmid_no_activity", npulse, 0);
            run_txn(1'b1, 8'h67, 16'h2468, 2'b11, 0, 1'b0, 1'b0, 16'h0000,
                    pk, acc, rd, bad, postp, prd_after);
            check("rstmid_next_pulse_cycle", pk, 3);
            check("rstmid_next_fields", bad, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
